// File: rtl/bbcd_pkg.sv
// Shared definitions for the binary-to-BCD conversion controller.
//   state_t        : controller state encoding (binary)
//   N_SHIFT        : shifts per conversion (the external counter loads N_SHIFT-1)
//   MAX_ITER       : SHIFT cycles allowed before the watchdog flags an error
//   ITER_W         : width of the watchdog iteration counter
//   REQ_ALU/ENTRY  : requester indices on the REQ/GNT/ACK vectors
package bbcd_pkg;

  localparam int N_SHIFT   = 16;
  localparam int MAX_ITER  = 20;
  localparam int ITER_W    = $clog2(MAX_ITER + 1);
  localparam int REQ_ALU   = 0;
  localparam int REQ_ENTRY = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/control_bbcd_arb_rr2.sv
// Combinational two-way round-robin arbiter.
//   req_i    : request vector, bit 0 = ALU, bit 1 = operand entry
//   rr_ptr_i : requester index that wins a tie
//   win_o    : one-hot winner, zero when nobody requests
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = 2'b00;
    if (rr_ptr_i) begin
      if (req_i[1])      win_o = 2'b10;
      else if (req_i[0]) win_o = 2'b01;
    end else begin
      if (req_i[0])      win_o = 2'b01;
      else if (req_i[1]) win_o = 2'b10;
    end
  end

endmodule

// File: rtl/control_bbcd.sv
// Sequencer and two-way arbiter for the shared double-dabble converter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : level requests [0]=ALU, [1]=entry, held until matching ack
//   z_i          : registered zero flag from the external iteration counter
//   ld_o, dec_o  : counter load (to N_SHIFT-1) and decrement
//   load_sr_o, add3_o, shift_o : datapath strobes
//   sel_o, gnt_o : registered input-mux select and one-hot grant
//   ack_o        : one-cycle completion pulse to the granted requester
//   busy_o       : high outside IDLE
//   err_o        : sticky watchdog flag, cleared by the next load
//
// state    | meaning
// IDLE     | waiting for a request; arbitrates and latches the grant on exit
// LOAD     | counter load and shift-register load, watchdog cleared
// ADD      | add-3 correction on every BCD nibble >= 5
// SHIFT    | shift {BCD,BIN} and decrement the counter; exit on Z or watchdog
// DONE     | acknowledge the granted requester, flip round-robin pointer
module control_bbcd (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       z_i,
  output logic       ld_o,
  output logic       dec_o,
  output logic       load_sr_o,
  output logic       add3_o,
  output logic       shift_o,
  output logic       sel_o,
  output logic [1:0] gnt_o,
  output logic [1:0] ack_o,
  output logic       busy_o,
  output logic       err_o
);

  import bbcd_pkg::*;

  // The watchdog must allow at least a full conversion.
  if (MAX_ITER <= N_SHIFT) begin : g_bad_cfg
    $error("MAX_ITER must exceed N_SHIFT");
  end

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              sel_q, sel_d;
  logic              err_q, err_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [1:0]        win;

  arb_rr2 u_arb (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .win_o    (win)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      iter_q   <= '0;
      gnt_q    <= 2'b00;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          state_d = ST_LOAD;
          gnt_d   = win;
          sel_d   = win[REQ_ENTRY];
        end
      end
      ST_LOAD: begin
        err_d   = 1'b0;
        iter_d  = '0;
        state_d = ST_ADD;
      end
      ST_ADD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        iter_d = iter_q + 1'b1;
        if (z_i) begin
          state_d = ST_DONE;
        end else if (iter_q == ITER_W'(MAX_ITER - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_DONE: begin
        rr_ptr_d = ~sel_q;
        gnt_d    = 2'b00;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore-decoded strobes
  assign ld_o      = (state_q == ST_LOAD);
  assign load_sr_o = (state_q == ST_LOAD);
  assign add3_o    = (state_q == ST_ADD);
  assign shift_o   = (state_q == ST_SHIFT);
  assign dec_o     = (state_q == ST_SHIFT);
  assign busy_o    = (state_q != ST_IDLE);
  assign ack_o     = (state_q == ST_DONE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign gnt_o     = gnt_q;
  assign sel_o     = sel_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_control_bbcd.sv
module tb_control_bbcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic       z;
  logic       ld, dec, load_sr, add3, shift, sel, busy, err;
  logic [1:0] gnt, ack;

  int n_checks = 0;
  int n_fail   = 0;
  int zmode    = 0;   // 0: counter model, 1: Z stuck 0, 2: Z stuck 1

  // Behavioural 5-bit LD/DEC counter with registered zero flag
  logic [4:0] cnt_m;
  logic       z_m;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_m <= 5'd0;
      z_m   <= 1'b0;
    end else if (ld) begin
      cnt_m <= 5'd15;
      z_m   <= 1'b0;
    end else begin
      if (dec) cnt_m <= cnt_m - 5'd1;
      z_m <= (cnt_m == 5'd0);
    end
  end

  assign z = (zmode == 1) ? 1'b0 : (zmode == 2) ? 1'b1 : z_m;

  control_bbcd dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .z_i       (z),
    .ld_o      (ld),
    .dec_o     (dec),
    .load_sr_o (load_sr),
    .add3_o    (add3),
    .shift_o   (shift),
    .sel_o     (sel),
    .gnt_o     (gnt),
    .ack_o     (ack),
    .busy_o    (busy),
    .err_o     (err)
  );

  typedef struct {
    bit         rst_before;
    logic [1:0] req;
    int         drop_at;
    logic [1:0] req_drop;
    logic [1:0] req_after;
    int         zmode;
    logic [1:0] exp_gnt;
    int         exp_ack_cyc;
    int         exp_ld;
    int         exp_cnt;     // add3 count and shift/dec count
    bit         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    zmode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int c, ack_c, ld_n, add_n, sh_n, dec_n, gnt_bad;
    logic [1:0] ack_v;
    bit got;
    if (v.rst_before) do_reset();
    zmode = v.zmode;
    req = v.req;
    c = 0; got = 0; ack_c = 0; ack_v = 2'b00;
    ld_n = 0; add_n = 0; sh_n = 0; dec_n = 0; gnt_bad = 0;
    while (!got && c < 60) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 1) begin
        chk($sformatf("row%0d gnt", idx), gnt, v.exp_gnt);
        chk($sformatf("row%0d sel", idx), sel, v.exp_gnt[1]);
      end
      if (c == v.drop_at) req = v.req_drop;
      ld_n  += ld;
      add_n += add3;
      sh_n  += shift;
      dec_n += dec;
      if (gnt != v.exp_gnt) gnt_bad++;
      if (ack != 2'b00) begin
        got = 1; ack_c = c; ack_v = ack;
      end
    end
    chk($sformatf("row%0d ack seen", idx), got, 1);
    chk($sformatf("row%0d ack cycle", idx), ack_c, v.exp_ack_cyc);
    chk($sformatf("row%0d ack value", idx), ack_v, v.exp_gnt);
    chk($sformatf("row%0d ld count", idx), ld_n, v.exp_ld);
    chk($sformatf("row%0d add3 count", idx), add_n, v.exp_cnt);
    chk($sformatf("row%0d shift count", idx), sh_n, v.exp_cnt);
    chk($sformatf("row%0d dec count", idx), dec_n, v.exp_cnt);
    chk($sformatf("row%0d err at ack", idx), err, v.exp_err);
    chk($sformatf("row%0d gnt held", idx), gnt_bad, 0);
    req = v.req_after;
    @(posedge clk);
    #1;
    chk($sformatf("row%0d idle busy", idx), busy, 0);
    chk($sformatf("row%0d idle gnt", idx), gnt, 0);
    chk($sformatf("row%0d idle ack", idx), ack, 0);
    chk($sformatf("row%0d idle err", idx), err, v.exp_err);
    zmode = 0;
  endtask

  initial begin
    int c;
    vec_t v;

    // 1 single ALU request
    vecs.push_back('{1, 2'b01, 0, 2'b00, 2'b00, 0, 2'b01, 34, 1, 16, 0});
    // 2 both after reset: ALU first, entry next
    vecs.push_back('{1, 2'b11, 0, 2'b00, 2'b10, 0, 2'b01, 34, 1, 16, 0});
    vecs.push_back('{0, 2'b10, 0, 2'b00, 2'b00, 0, 2'b10, 34, 1, 16, 0});
    // 3 both held continuously: alternating grants
    vecs.push_back('{1, 2'b11, 0, 2'b00, 2'b11, 0, 2'b01, 34, 1, 16, 0});
    vecs.push_back('{0, 2'b11, 0, 2'b00, 2'b11, 0, 2'b10, 34, 1, 16, 0});
    vecs.push_back('{0, 2'b11, 0, 2'b00, 2'b11, 0, 2'b01, 34, 1, 16, 0});
    vecs.push_back('{0, 2'b11, 0, 2'b00, 2'b00, 0, 2'b10, 34, 1, 16, 0});
    // 4 Z stuck low: watchdog after 20 shifts, next load clears err
    vecs.push_back('{1, 2'b01, 0, 2'b00, 2'b00, 1, 2'b01, 42, 1, 20, 1});
    vecs.push_back('{0, 2'b10, 0, 2'b00, 2'b00, 0, 2'b10, 34, 1, 16, 0});
    // Z already high at the first shift: one shift, no err
    vecs.push_back('{1, 2'b10, 0, 2'b00, 2'b00, 2, 2'b10, 4, 1, 1, 0});
    // 6 ALU drops request at cycle 10, entry waits
    vecs.push_back('{1, 2'b11, 10, 2'b10, 2'b10, 0, 2'b01, 34, 1, 16, 0});
    vecs.push_back('{0, 2'b10, 0, 2'b00, 2'b00, 0, 2'b10, 34, 1, 16, 0});

    // reset state
    rst = 1'b1;
    #2;
    chk("reset outputs",
        {ld, dec, load_sr, add3, shift, sel, gnt, ack, busy, err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

    // 5 reset during the 7th shift (cycle 15), then a fresh request
    do_reset();
    req = 2'b01;
    c = 0;
    while (c < 15) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("rst seq 7th shift", shift, 1);
    rst = 1'b1;
    #1;
    chk("rst seq outputs",
        {ld, dec, load_sr, add3, shift, sel, gnt, ack, busy, err}, 0);
    req = 2'b00;
    @(posedge clk);
    #1;
    chk("rst seq no ack", ack, 0);
    chk("rst seq busy", busy, 0);
    rst = 1'b0;
    v = '{0, 2'b01, 0, 2'b00, 2'b00, 0, 2'b01, 34, 1, 16, 0};
    run_row(v, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
